clint_timer: RTL and testbench
==============================

// Module: clint_timer
// PURPOSE
//  - Memory-mapped machine timer and software-interrupt source (CLINT subset) for the RV32I core.
//  - Holds 64-bit mtime/mtimecmp and raises a level timer interrupt.
//  - Sits upstream of the CSR/exception path: timer_irq_o feeds the interrupt controller, which
//    gates it with mie/mstatus and issues excepttype "timer" to the CSR block.
//  - Read/written by the data-memory stage over a single-cycle request/ack bus.
// PARAMETERS
//  BASE_ADDR  32'h0200_0000  block base; decode compares addr_i[31:16] == BASE_ADDR[31:16]
//  PRESCALE   1              clk cycles per mtime increment; legal range 1..65535
// PORTS
//  clk         in   1   clock
//  rst         in   1   reset, synchronous, active-high
//  req_i       in   1   bus request, one-cycle pulse per access
//  we_i        in   1   1 = write, 0 = read; qualified by req_i
//  addr_i      in   32  byte address, word aligned; addr_i[1:0] ignored
//  wdata_i     in   32  write data, full-word writes only
//  rdata_o     out  32  read data, valid while ack_o = 1
//  ack_o       out  1   access complete, one cycle after req_i
//  mtime_o     out  64  current mtime, for time/timeh CSR reads
//  timer_irq_o out  1   level timer interrupt, registered (mtime >= mtimecmp)
//  soft_irq_o  out  1   machine software interrupt, msip[0]
// BEHAVIOUR
//  - Reset values:
//    - mtime = 0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; prescale counter = 0
//    - msip = 0; rdata_o = 0; ack_o = 0; timer_irq_o = 0; soft_irq_o = 0
//  - Register map (offset = addr_i[15:0]):
//    - 0x0000 msip
//    - 0x4000 mtimecmp[31:0], 0x4004 mtimecmp[63:32]
//    - 0xBFF8 mtime[31:0], 0xBFFC mtime[63:32]
//  - Unmapped offset or base mismatch while req_i = 1: write ignored, read returns 0, ack_o still pulses.
//  - Bus timing:
//    - Request sampled on the clk edge where req_i = 1.
//    - ack_o = 1 on the following cycle only; rdata_o updates in that same cycle.
//    - rdata_o holds its value until the next ack.
//    - Back-to-back requests are accepted every cycle; there is no stall.
//  - Read value: the register content on the request edge, before any same-edge update.
//  - Write effect: the register takes wdata_i at the request edge; visible from the next cycle.
//  - Prescaler:
//    - Counts 0..PRESCALE-1, then wraps to 0.
//    - A tick is the cycle in which the count equals PRESCALE-1; PRESCALE=1 ticks every cycle.
//  - mtime:
//    - Increments by 1 on each tick, unsigned 64-bit, wraps FFFF..FF -> 0.
//    - Carry propagates from the low half into the high half.
//  - Write/tick collision: a write to either mtime half in a tick cycle wins. Both halves are
//    written/held; no increment occurs that cycle. The prescaler keeps running.
//  - Writes to one half never carry or modify the other half.
//  - timer_irq_o:
//    - Registered each cycle as the unsigned 64-bit compare mtime >= mtimecmp on current
//      register values, giving one cycle latency after the condition changes.
//    - Deasserts one cycle after a mtimecmp/mtime write makes the compare false.
//    - There is no sticky pending bit.
//  - Reset mid-operation: all state returns to reset values on that edge. An outstanding
//    ack is dropped, so ack_o = 0 in the next cycle.
// CONFIGURATION
//  CLINT_MSIP_EN defined:
//    - msip register exists; bit 0 is writable, bits [31:1] read 0.
//    - soft_irq_o = msip[0], registered, updating one cycle after the write.
//  CLINT_MSIP_EN undefined:
//    - Offset 0x0000 reads 0 and writes are ignored; soft_irq_o tied 0.
// TESTING
//  1. Reset, then read 0xBFF8/0xBFFC/0x4000/0x4004 -> 0 / 0 / FFFFFFFF / FFFFFFFF; timer_irq_o = 0.
//  2. PRESCALE=4, run 40 cycles after rst drops -> mtime_o = 10; PRESCALE=1, 40 cycles -> mtime_o = 40.
//  3. PRESCALE=1, write 0x4004=0 then 0x4000=20:
//     - timer_irq_o rises the cycle after mtime_o reaches 20.
//     - Then write 0x4000=1000 -> timer_irq_o = 0 one cycle later.
//  4. Write 0xBFFC=FFFFFFFF and 0xBFF8=FFFFFFFF, then one tick -> mtime_o = 64'h0.
//     Write 0xBFF8=FFFFFFFF only (hi = 0), then one tick -> mtime_o = 64'h1_0000_0000.
//  5. PRESCALE=1, write 0xBFF8=5 -> mtime_o[31:0] = 5 (not 6) the next cycle, then 6.
//     A read at offset 0x1234 -> ack_o = 1, rdata_o = 0.
//  6. With CLINT_MSIP_EN, write 0x0000=3 -> soft_irq_o = 1 next cycle, read returns 1;
//     without the macro -> read returns 0, soft_irq_o stays 0.

Source files
------------

// File: rtl/clint_timer.sv
`timescale 1ns/1ps
// clint_timer: CLINT subset with 64-bit mtime/mtimecmp, a registered level timer interrupt and a
// single-cycle request/ack bus. Define CLINT_MSIP_EN to implement the msip register and soft_irq_o.
module clint_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic [63:0] mtime_o,
  output logic        timer_irq_o,
  output logic        soft_irq_o
);

  localparam logic [15:0] OffMsip    = 16'h0000;
  localparam logic [15:0] OffCmpLo   = 16'h4000;
  localparam logic [15:0] OffCmpHi   = 16'h4004;
  localparam logic [15:0] OffTimeLo  = 16'hBFF8;
  localparam logic [15:0] OffTimeHi  = 16'hBFFC;
  localparam logic [15:0] PreLast    = 16'(PRESCALE - 1);

  logic [15:0] pre_q, pre_d;
  logic        tick;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_val;
  logic        ack_q;
  logic        irq_q, irq_d;
  logic        sel;
  logic        wr;
  logic [15:0] off;
  logic        msip_rd;
  logic        unused_addr;

  // Word-aligned bus: byte offset bits carry no meaning.
  assign unused_addr = ^addr_i[1:0];

  assign sel = req_i && (addr_i[31:16] == BASE_ADDR[31:16]);
  assign wr  = sel && we_i;
  assign off = {addr_i[15:2], 2'b00};

`ifdef CLINT_MSIP_EN
  logic msip_q, msip_d;

  always_comb begin
    msip_d = msip_q;
    if (wr && (off == OffMsip)) msip_d = wdata_i[0];
  end

  always_ff @(posedge clk) begin
    if (rst) msip_q <= 1'b0;
    else     msip_q <= msip_d;
  end

  assign msip_rd = msip_q;
`else
  assign msip_rd = 1'b0;
`endif

  assign soft_irq_o = msip_rd;

  always_comb begin
    tick  = (pre_q == PreLast);
    pre_d = tick ? 16'd0 : pre_q + 16'd1;
  end

  // A write to either mtime half suppresses that cycle's increment.
  always_comb begin
    mtime_d = mtime_q;
    if (wr && (off == OffTimeLo)) begin
      mtime_d[31:0] = wdata_i;
    end else if (wr && (off == OffTimeHi)) begin
      mtime_d[63:32] = wdata_i;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (wr && (off == OffCmpLo)) mtimecmp_d[31:0]  = wdata_i;
    if (wr && (off == OffCmpHi)) mtimecmp_d[63:32] = wdata_i;
  end

  always_comb begin
    rd_val = '0;
    if (sel) begin
      case (off)
        OffMsip:   rd_val = {31'd0, msip_rd};
        OffCmpLo:  rd_val = mtimecmp_q[31:0];
        OffCmpHi:  rd_val = mtimecmp_q[63:32];
        OffTimeLo: rd_val = mtime_q[31:0];
        OffTimeHi: rd_val = mtime_q[63:32];
        default:   rd_val = '0;
      endcase
    end
  end

  always_comb begin
    rdata_d = req_i ? rd_val : rdata_q;
    irq_d   = (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q      <= 16'd0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      rdata_q    <= 32'd0;
      ack_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      rdata_q    <= rdata_d;
      ack_q      <= req_i;
      irq_q      <= irq_d;
    end
  end

  assign rdata_o     = rdata_q;
  assign ack_o       = ack_q;
  assign mtime_o     = mtime_q;
  assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_clint_timer.sv
`timescale 1ns/1ps
// Bench for clint_timer: directed steps then random bus traffic, checked every cycle against a
// behavioural model (PRESCALE=1 instance) and an elapsed-cycle formula (PRESCALE=4 instance).
module tb_clint_timer;

  localparam logic [31:0] Base = 32'h0200_0000;
`ifdef CLINT_MSIP_EN
  localparam bit MsipEn = 1'b1;
`else
  localparam bit MsipEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic [63:0] mtime_o;
  logic        timer_irq_o;
  logic        soft_irq_o;

  logic [31:0] rdata_b;
  logic        ack_b;
  logic [63:0] mtime_b;
  logic        irq_b;
  logic        soft_b;

  int tests = 0;
  int fails = 0;

  // Reference state
  logic [63:0] m_time;
  logic [63:0] m_cmp;
  logic        m_msip;
  logic        m_irq;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic [63:0] n_b;

  always #5 clk = ~clk;

  clint_timer #(.BASE_ADDR(Base), .PRESCALE(1)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .ack_o       (ack_o),
    .mtime_o     (mtime_o),
    .timer_irq_o (timer_irq_o),
    .soft_irq_o  (soft_irq_o)
  );

  clint_timer #(.BASE_ADDR(Base), .PRESCALE(4)) u_dut_pre4 (
    .clk         (clk),
    .rst         (rst),
    .req_i       (1'b0),
    .we_i        (1'b0),
    .addr_i      (32'd0),
    .wdata_i     (32'd0),
    .rdata_o     (rdata_b),
    .ack_o       (ack_b),
    .mtime_o     (mtime_b),
    .timer_irq_o (irq_b),
    .soft_irq_o  (soft_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [15:0] off;
    off = {a[15:2], 2'b00};
    if (a[31:16] != Base[31:16]) return 32'd0;
    case (off)
      16'h0000: return MsipEn ? {31'd0, m_msip} : 32'd0;
      16'h4000: return m_cmp[31:0];
      16'h4004: return m_cmp[63:32];
      16'hBFF8: return m_time[31:0];
      16'hBFFC: return m_time[63:32];
      default:  return 32'd0;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic rq, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
    logic [15:0] off;
    logic        hit;
    logic        time_wr;
    if (r) begin
      m_time  = 64'd0;
      m_cmp   = '1;
      m_msip  = 1'b0;
      m_irq   = 1'b0;
      m_ack   = 1'b0;
      m_rdata = 32'd0;
      n_b     = 64'd0;
      return;
    end
    off     = {a[15:2], 2'b00};
    hit     = rq && (a[31:16] == Base[31:16]);
    time_wr = 1'b0;
    m_irq   = (m_time >= m_cmp);
    m_ack   = rq;
    if (rq) m_rdata = model_read(a);
    if (hit && w) begin
      case (off)
        16'h0000: if (MsipEn) m_msip = d[0];
        16'h4000: m_cmp[31:0] = d;
        16'h4004: m_cmp[63:32] = d;
        16'hBFF8: begin m_time[31:0] = d; time_wr = 1'b1; end
        16'hBFFC: begin m_time[63:32] = d; time_wr = 1'b1; end
        default: ;
      endcase
    end
    if (!time_wr) m_time = m_time + 64'd1;
    n_b = n_b + 64'd1;
  endtask

  task automatic step(input logic r, input logic rq, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = r; req_i = rq; we_i = w; addr_i = a; wdata_i = d;
    @(posedge clk);
    model_edge(r, rq, w, a, d);
    #1;
    check("mtime", mtime_o, m_time);
    check("timer_irq", {63'd0, timer_irq_o}, {63'd0, m_irq});
    check("ack", {63'd0, ack_o}, {63'd0, m_ack});
    check("rdata", {32'd0, rdata_o}, {32'd0, m_rdata});
    check("soft_irq", {63'd0, soft_irq_o}, {63'd0, MsipEn & m_msip});
    check("mtime_pre4", mtime_b, n_b / 4);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic wr32(input logic [15:0] off, input logic [31:0] d);
    step(1'b0, 1'b1, 1'b1, {Base[31:16], off}, d);
  endtask

  task automatic rd32(input logic [15:0] off);
    step(1'b0, 1'b1, 1'b0, {Base[31:16], off}, 32'hDEAD_BEEF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [15:0] off;
    logic        r;
    logic        rq;
    logic        w;
    int          guard;

    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = 32'd0; wdata_i = 32'd0;
    m_time = '0; m_cmp = '1; m_msip = 1'b0; m_irq = 1'b0; m_ack = 1'b0; m_rdata = '0; n_b = '0;

    // Reset values and register readback
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    check("rst_mtime", mtime_o, 64'd0);
    check("rst_irq", {63'd0, timer_irq_o}, 64'd0);
    rd32(16'hBFF8);
    check("rd_mtime_lo", {32'd0, rdata_o}, 64'd0);
    rd32(16'hBFFC);
    check("rd_mtime_hi", {32'd0, rdata_o}, 64'd0);
    rd32(16'h4000);
    check("rd_cmp_lo", {32'd0, rdata_o}, 64'hFFFF_FFFF);
    rd32(16'h4004);
    check("rd_cmp_hi", {32'd0, rdata_o}, 64'hFFFF_FFFF);

    // 40 cycles after reset release
    for (int i = 0; i < 36; i++) idle();
    check("prescale1_40", mtime_o, 64'd40);
    check("prescale4_40", mtime_b, 64'd10);

    // Timer compare rise and fall
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    wr32(16'h4004, 32'd0);
    wr32(16'h4000, 32'd20);
    guard = 0;
    while (m_time != 64'd20 && guard < 100) begin
      idle();
      guard++;
    end
    check("cmp_reach", mtime_o, 64'd20);
    check("irq_before", {63'd0, timer_irq_o}, 64'd0);
    idle();
    check("irq_rise", {63'd0, timer_irq_o}, 64'd1);
    wr32(16'h4000, 32'd1000);
    idle();
    check("irq_fall", {63'd0, timer_irq_o}, 64'd0);

    // mtime wrap and low-to-high carry
    wr32(16'hBFFC, 32'hFFFF_FFFF);
    wr32(16'hBFF8, 32'hFFFF_FFFF);
    idle();
    check("wrap", mtime_o, 64'd0);
    wr32(16'hBFFC, 32'd0);
    wr32(16'hBFF8, 32'hFFFF_FFFF);
    idle();
    check("carry", mtime_o, 64'h1_0000_0000);

    // Write beats tick; unmapped and foreign-base accesses
    wr32(16'hBFF8, 32'd5);
    check("wr_wins", {32'd0, mtime_o[31:0]}, 64'd5);
    idle();
    check("wr_then_inc", {32'd0, mtime_o[31:0]}, 64'd6);
    rd32(16'h1234);
    check("unmapped_ack", {63'd0, ack_o}, 64'd1);
    check("unmapped_rd", {32'd0, rdata_o}, 64'd0);
    step(1'b0, 1'b1, 1'b1, 32'h0300_4000, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0300_BFF8, 32'd0);
    check("foreign_rd", {32'd0, rdata_o}, 64'd0);

    // Software interrupt register
    wr32(16'h0000, 32'd3);
    check("msip_irq", {63'd0, soft_irq_o}, {63'd0, MsipEn});
    rd32(16'h0000);
    check("msip_rd", {32'd0, rdata_o}, {63'd0, MsipEn});

    // Reset on the same edge as a request drops the ack
    rd32(16'h4000);
    step(1'b1, 1'b1, 1'b0, {Base[31:16], 16'hBFF8}, 32'd0);
    check("rst_drop_ack", {63'd0, ack_o}, 64'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 63) == 0);
      rq = ($urandom_range(0, 9) < 7);
      w  = $urandom_range(0, 1);
      case ($urandom_range(0, 7))
        0: begin off = 16'h0000; d = $urandom; end
        1: begin off = 16'h4000; d = m_time[31:0] + 32'($urandom_range(0, 16)) - 32'd8; end
        2: begin off = 16'h4004; d = m_time[63:32] + 32'($urandom_range(0, 1)); end
        3: begin off = 16'hBFF8; d = $urandom; end
        4: begin off = 16'hBFFC; d = 32'($urandom_range(0, 3)); end
        5: begin off = 16'h1234; d = $urandom; end
        default: begin off = 16'($urandom); d = $urandom; end
      endcase
      a = {Base[31:16], off[15:2], 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 15) == 0) a[31:16] = 16'h0300;
      step(r, rq, w, a, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
